vtiming_cfg_seq: RTL and testbench
==================================

# vtiming_cfg_seq

AXI4-Lite configuration sequencer for the vtiming_gen register bank. On a start pulse it writes a latched table of register values to consecutive slave addresses, reads back each word and checks it. It reports completion and the first failing register. It sits between the system control logic and the vtiming_gen S_AXI port, replacing host/BFM-driven bring-up.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 32, data width (only 32 supported)
- C_BASE_ADDR, 32'h0000_0000, slave address of register 0
- C_NUM_REGS, 4, registers to program (1..16)
- C_VERIFY, 1, 1 = read back and compare each register; 0 = write only

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  asynchronous, active-low reset
- start  in  1  begin sequence; honoured only when idle
- cfg_data  in  32*C_NUM_REGS  register values, reg i in bits [32i+31:32i]
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at end of sequence (pass or fail)
- error  out  1  sticky fail flag, cleared on accepted start
- err_idx  out  4  index of first failing register
- err_code  out  2  01 BRESP not OKAY, 10 RRESP not OKAY, 11 data mismatch
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY  write channels
- M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY  read channels

## Operation
- Reset: state IDLE; busy, done, error, all VALID/READY outputs 0; err_idx, err_code 0; AWADDR/ARADDR C_BASE_ADDR; WDATA 0.
- AWPROT = ARPROT = 3'b000; WSTRB = 4'hF always.
- IDLE: on start=1, latch cfg_data into internal table, idx←0, clear error/err_idx/err_code, go WADDR. start while busy is ignored; later cfg_data changes do not affect a running sequence.
- WADDR: AWVALID and WVALID asserted together, AWADDR = C_BASE_ADDR + 4*idx, WDATA = table[idx]. Each VALID drops independently on its own handshake (VALID&READY). Leave when both have handshaken → WRESP.
- WRESP: BREADY=1. On BVALID: BRESP≠00 → fail(01); else C_VERIFY ? RADDR : next.
- RADDR: ARVALID=1, ARADDR = C_BASE_ADDR + 4*idx; on ARREADY → RDATA.
- RDATA: RREADY=1. On RVALID: RRESP≠00 → fail(10); RDATA≠table[idx] → fail(11); else next.
- next: idx = C_NUM_REGS-1 → FIN; else idx←idx+1, WADDR.
- fail(c): error←1, err_idx←idx, err_code←c, → FIN (remaining registers skipped).
- FIN: done=1 for one cycle, busy=0, → IDLE.
- busy = 1 in WADDR, WRESP, RADDR, RDATA; 0 in IDLE, FIN.
- VALID never deasserted before handshake; address/data stable while VALID high.

## Timing
- start sampled at ACLK edge k; AWVALID/WVALID/busy high from k+1.
- Zero-wait slave (READY always 1, B/R one cycle after request): 4 cycles per register with C_VERIFY=1 (WADDR, WRESP, RADDR, RDATA), 2 with C_VERIFY=0; done at cycle k+1+4*C_NUM_REGS.
- AWREADY and WREADY in different cycles: WADDR persists until the later one; no re-issue of the earlier channel.
- Simultaneous start and FIN: start ignored (FIN not idle); start in the IDLE cycle after FIN accepted.
- No timeout: a hung slave holds busy indefinitely; only ARESETN recovers.
- ARESETN asserted mid-sequence: all outputs go to reset values immediately (asynchronous); no done pulse.

## Test plan
- Zero-wait slave, cfg = {0xBEEF0011, 0xDEAD0011, 0xABCD0001, 0x0101FFFF}, C_BASE_ADDR=0: writes to 0x0,0x4,0x8,0xC with those data in order, each read back; done at start+17 cycles, error=0.
- Slave corrupts read of reg 2 (returns 0xDEAD0010): error=1, err_idx=2, err_code=11, no AW issued to 0xC, done pulses once.
- Slave returns BRESP=10 on reg 1: error=1, err_idx=1, err_code=01, no AR to 0x4.
- Random AWREADY/WREADY/ARREADY/BVALID/RVALID delays 0-5 cycles, 50 runs: every VALID held until handshake, addresses/data stable, all pass.
- start pulsed while busy and cfg_data changed mid-run: no second sequence, written data equals values latched at first start.
- ARESETN low during WRESP of reg 1: all outputs 0 asynchronously; after release a new start runs full sequence from reg 0.

Source files
------------

// File: rtl/vtiming_cfg_seq.sv
// vtiming_cfg_seq
// AXI4-Lite master that programs the vtiming_gen register bank. On an accepted
// start it latches cfg_data, writes each word to C_BASE_ADDR + 4*i, optionally
// reads it back and compares, then pulses done. The first failure stops the
// sequence and is reported through error/err_idx/err_code.
//
// Ports:
//   ACLK, ARESETN       clock (rising edge), asynchronous active-low reset
//   start               begin a sequence (only honoured in IDLE)
//   cfg_data            register table, reg i in bits [32i+31:32i]
//   busy, done          sequence running / one-cycle end-of-sequence pulse
//   error, err_idx,     sticky failure flag, index of the failing register,
//   err_code            01 BRESP, 10 RRESP, 11 read-back data mismatch
//   dbg_state_o         current FSM state
//   M_AXI_*             AXI4-Lite master write (AW/W/B) and read (AR/R) channels
//
// Handshake rule for every channel: a transfer happens on a rising edge where
// VALID and READY are both high; VALID, once raised, stays high with its
// address/data stable until that transfer, and READY never waits on VALID.
module vtiming_cfg_seq #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
  parameter int                            C_NUM_REGS         = 4,
  parameter bit                            C_VERIFY           = 1'b1
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETN,
  input  logic                                     start,
  input  logic [C_M_AXI_DATA_WIDTH*C_NUM_REGS-1:0] cfg_data,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     error,
  output logic [3:0]                               err_idx,
  output logic [1:0]                               err_code,
  output logic [2:0]                               dbg_state_o,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_AWADDR,
  output logic [2:0]                               M_AXI_AWPROT,
  output logic                                     M_AXI_AWVALID,
  input  logic                                     M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]          M_AXI_WSTRB,
  output logic                                     M_AXI_WVALID,
  input  logic                                     M_AXI_WREADY,
  input  logic [1:0]                               M_AXI_BRESP,
  input  logic                                     M_AXI_BVALID,
  output logic                                     M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_ARADDR,
  output logic [2:0]                               M_AXI_ARPROT,
  output logic                                     M_AXI_ARVALID,
  input  logic                                     M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_RDATA,
  input  logic [1:0]                               M_AXI_RRESP,
  input  logic                                     M_AXI_RVALID,
  output logic                                     M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            error_q, error_d;
  logic [3:0]      err_idx_q, err_idx_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [DW-1:0]   tbl_q [C_NUM_REGS];
  logic            load_tbl;
  logic [DW-1:0]   cur_word;
  logic [AW-1:0]   addr_off;
  logic            last_reg;
  logic            aw_hs, w_hs;

  // Word selected by the current register index.
  always_comb begin
    cur_word = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx_q == 4'(i)) cur_word = tbl_q[i];
    end
  end

  always_comb begin
    addr_off      = '0;
    addr_off[5:0] = {idx_q, 2'b00};
  end

  assign last_reg = (idx_q == 4'(C_NUM_REGS - 1));

  // AW and W complete independently; each VALID drops after its own transfer.
  assign M_AXI_AWVALID = (state_q == S_WADDR) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == S_WADDR) && !w_done_q;
  assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs          = M_AXI_WVALID && M_AXI_WREADY;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    error_d    = error_q;
    err_idx_d  = err_idx_q;
    err_code_d = err_code_q;
    load_tbl   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_tbl   = 1'b1;
          idx_d      = '0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          error_d    = 1'b0;
          err_idx_d  = '0;
          err_code_d = '0;
          state_d    = S_WADDR;
        end
      end
      S_WADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WRESP;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            error_d    = 1'b1;
            err_idx_d  = idx_q;
            err_code_d = 2'b01;
            state_d    = S_FIN;
          end else if (C_VERIFY) begin
            state_d = S_RADDR;
          end else if (last_reg) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_WADDR;
          end
        end
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00) begin
            error_d    = 1'b1;
            err_idx_d  = idx_q;
            err_code_d = 2'b10;
            state_d    = S_FIN;
          end else if (M_AXI_RDATA != cur_word) begin
            error_d    = 1'b1;
            err_idx_d  = idx_q;
            err_code_d = 2'b11;
            state_d    = S_FIN;
          end else if (last_reg) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_WADDR;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
      err_code_q <= err_code_d;
    end
  end

  // The table is only loaded on an accepted start, so cfg_data may change
  // freely while a sequence runs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < C_NUM_REGS; i++) tbl_q[i] <= '0;
    end else if (load_tbl) begin
      for (int i = 0; i < C_NUM_REGS; i++) tbl_q[i] <= cfg_data[i*DW +: DW];
    end
  end

  assign M_AXI_AWADDR = C_BASE_ADDR + addr_off;
  assign M_AXI_ARADDR = C_BASE_ADDR + addr_off;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WDATA  = cur_word;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_BREADY = (state_q == S_WRESP);
  assign M_AXI_ARVALID = (state_q == S_RADDR);
  assign M_AXI_RREADY = (state_q == S_RDATA);

  assign busy        = (state_q == S_WADDR) || (state_q == S_WRESP) ||
                       (state_q == S_RADDR) || (state_q == S_RDATA);
  assign done        = (state_q == S_FIN);
  assign error       = error_q;
  assign err_idx     = err_idx_q;
  assign err_code    = err_code_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vtiming_cfg_seq.sv
// Bench for vtiming_cfg_seq: an AXI4-Lite slave with random per-transfer
// delays, a reference model listing the transfers and final status implied by
// the configuration table, and directed scenarios around faults and reset.
module tb_vtiming_cfg_seq;
  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic [32*N-1:0] cfg_data = '0;
  logic           busy, done, error;
  logic [3:0]     err_idx;
  logic [1:0]     err_code;
  logic [2:0]     dbg_state;
  logic [31:0]    awaddr, araddr, wdata, rdata;
  logic [2:0]     awprot, arprot;
  logic [3:0]     wstrb;
  logic           awvalid, wvalid, bready, arvalid, rready;
  logic           awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0]     bresp = 2'b00, rresp = 2'b00;

  vtiming_cfg_seq #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_BASE_ADDR(BASE),
    .C_NUM_REGS(N), .C_VERIFY(1'b1)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx),
    .err_code(err_code), .dbg_state_o(dbg_state),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];     // expected writes {addr, data}
  logic [63:0] wr_log[$];    // observed writes
  logic [31:0] exp_ar_q[$];  // expected read addresses
  logic [31:0] ar_log[$];    // observed read addresses
  logic        exp_err;
  logic [3:0]  exp_idx;
  logic [1:0]  exp_code;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: walk the table in order, stop at the first fault.
  task automatic build_expect(input logic [32*N-1:0] cfg, input int bb, input int brr, input int brd);
    exp_q.delete(); exp_ar_q.delete();
    exp_err = 0; exp_idx = 0; exp_code = 0;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({BASE + 32'(4 * i), cfg[32*i +: 32]});
      if (i == bb) begin exp_err = 1; exp_idx = 4'(i); exp_code = 2'b01; break; end
      exp_ar_q.push_back(BASE + 32'(4 * i));
      if (i == brr) begin exp_err = 1; exp_idx = 4'(i); exp_code = 2'b10; break; end
      if (i == brd) begin exp_err = 1; exp_idx = 4'(i); exp_code = 2'b11; break; end
    end
  endtask

  function automatic logic [127:0] outvec();
    return {dbg_state, busy, done, error, err_idx, err_code, awvalid, wvalid,
            bready, arvalid, rready, awprot, arprot, wstrb, awaddr, araddr, wdata};
  endfunction

  localparam logic [127:0] RST_VEC = {3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0,
                                      3'd0, 3'd0, 4'hF, BASE, BASE, 32'd0};

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // ---------------- slave model ----------------
  int max_dly = 0;
  int bad_b_idx = -1, bad_rr_idx = -1, bad_rd_idx = -1;
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  bit aw_got = 0, w_got = 0, ar_got = 0;
  bit aw_pend = 0, w_pend = 0, ar_pend = 0;
  logic [31:0] aw_hold, w_hold, ar_hold, aw_a, w_d, ar_a;
  logic [31:0] mem [16];
  int ri;

  function automatic int a2i(input logic [31:0] a);
    return int'((a - BASE) >> 2) & 15;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_got = 0; w_got = 0; ar_got = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    end else begin
      // AW: READY raised only while VALID is seen, so the transfer lands on the next edge
      if (awready) begin
        awready = 0; aw_got = 1; aw_pend = 0; aw_a = aw_hold;
        aw_wait = $urandom_range(max_dly, 0);
      end else begin
        if (aw_pend) begin
          chk("aw_hold", {awvalid, awaddr}, {1'b1, aw_hold});
          if (!awvalid) aw_pend = 0;
        end
        if (awvalid && !aw_got) begin
          if (!aw_pend) begin aw_pend = 1; aw_hold = awaddr; end
          if (aw_wait == 0) awready = 1; else aw_wait--;
        end
      end
      // W
      if (wready) begin
        wready = 0; w_got = 1; w_pend = 0; w_d = w_hold;
        w_wait = $urandom_range(max_dly, 0);
      end else begin
        if (w_pend) begin
          chk("w_hold", {wvalid, wdata, wstrb}, {1'b1, w_hold, 4'hF});
          if (!wvalid) w_pend = 0;
        end
        if (wvalid && !w_got) begin
          if (!w_pend) begin w_pend = 1; w_hold = wdata; end
          if (w_wait == 0) wready = 1; else w_wait--;
        end
      end
      // B
      if (bvalid) begin
        bvalid = 0; aw_got = 0; w_got = 0; b_wait = $urandom_range(max_dly, 0);
      end else if (aw_got && w_got && bready) begin
        if (b_wait == 0) begin
          bvalid = 1;
          bresp = (a2i(aw_a) == bad_b_idx) ? 2'b10 : 2'b00;
          mem[a2i(aw_a)] = w_d;
          wr_log.push_back({aw_a, w_d});
        end else b_wait--;
      end
      // AR
      if (arready) begin
        arready = 0; ar_got = 1; ar_pend = 0; ar_a = ar_hold;
        ar_wait = $urandom_range(max_dly, 0);
      end else begin
        if (ar_pend) begin
          chk("ar_hold", {arvalid, araddr}, {1'b1, ar_hold});
          if (!arvalid) ar_pend = 0;
        end
        if (arvalid && !ar_got) begin
          if (!ar_pend) begin ar_pend = 1; ar_hold = araddr; end
          if (ar_wait == 0) arready = 1; else ar_wait--;
        end
      end
      // R
      if (rvalid) begin
        rvalid = 0; ar_got = 0; r_wait = $urandom_range(max_dly, 0);
      end else if (ar_got && rready) begin
        if (r_wait == 0) begin
          ri = a2i(ar_a);
          rvalid = 1;
          rresp = (ri == bad_rr_idx) ? 2'b10 : 2'b00;
          rdata = mem[ri] ^ ((ri == bad_rd_idx) ? 32'h1 : 32'h0);
          ar_log.push_back(ar_a);
        end else r_wait--;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic seed_waits(input int dly);
    max_dly = dly;
    aw_wait = $urandom_range(dly, 0); w_wait = $urandom_range(dly, 0);
    b_wait = $urandom_range(dly, 0); ar_wait = $urandom_range(dly, 0);
    r_wait = $urandom_range(dly, 0);
  endtask

  task automatic run_seq(input logic [32*N-1:0] cfg, input int bb, input int brr,
                         input int brd, input int dly, input bit disturb, input bit chk_lat);
    int cyc;
    bit got;
    int base_done;
    wr_log.delete(); ar_log.delete();
    bad_b_idx = bb; bad_rr_idx = brr; bad_rd_idx = brd;
    seed_waits(dly);
    build_expect(cfg, bb, brr, brd);
    base_done = done_cnt;
    @(negedge clk);
    cfg_data = cfg;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    if (disturb) cfg_data = {$urandom, $urandom, $urandom, $urandom};
    cyc = 0; got = 0;
    while (cyc < 2000 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_first", {busy, awvalid, wvalid}, 3'b111);
      if (disturb && cyc == 3) start = 1;
      if (disturb && cyc == 4) start = 0;
      if (done === 1'b1) got = 1;
    end
    start = 0;
    chk("done_seen", got, 1'b1);
    if (!got) begin
      rst_n = 0; repeat (2) @(negedge clk); rst_n = 1;
    end
    if (chk_lat) chk("latency", cyc, 1 + 4 * N);
    chk("status", {error, err_idx, err_code}, {exp_err, exp_idx, exp_code});
    repeat (8) @(negedge clk);
    chk("idle_after", {busy, 32'(done_cnt - base_done)}, {1'b0, 32'd1});
    chk("status_hold", {error, err_idx, err_code}, {exp_err, exp_idx, exp_code});
    chk("wr_count", wr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) chk("wr_entry", wr_log[i], exp_q[i]);
    chk("ar_count", ar_log.size(), exp_ar_q.size());
    for (int i = 0; i < exp_ar_q.size() && i < ar_log.size(); i++) chk("ar_entry", ar_log[i], exp_ar_q[i]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [32*N-1:0] cfg_a;
    logic [32*N-1:0] cfg_r;
    int nb, guard, base_done;
    logic prev;
    cfg_a = {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF};

    repeat (2) @(negedge clk);
    chk("reset_state", outvec(), RST_VEC);
    rst_n = 1;
    @(negedge clk);
    chk("idle_state", outvec(), RST_VEC);

    // zero-wait slave, full pass with latency
    run_seq(cfg_a, -1, -1, -1, 0, 0, 1);
    // corrupted read-back of reg 2
    run_seq(cfg_a, -1, -1, 2, 0, 0, 0);
    // write error on reg 1
    run_seq(cfg_a, 1, -1, -1, 0, 0, 0);
    // read response error on reg 0
    run_seq(cfg_a, -1, 0, -1, 2, 0, 0);

    // random data and random slave delays
    for (int r = 0; r < 50; r++) begin
      cfg_r = {$urandom, $urandom, $urandom, $urandom};
      run_seq(cfg_r, -1, -1, -1, 5, 0, 0);
    end

    // start re-pulsed while busy, cfg_data changed mid-run
    cfg_r = {$urandom, $urandom, $urandom, $urandom};
    run_seq(cfg_r, -1, -1, -1, 2, 1, 0);

    // reset during WRESP of reg 1
    wr_log.delete(); ar_log.delete();
    bad_b_idx = -1; bad_rr_idx = -1; bad_rd_idx = -1;
    seed_waits(0);
    base_done = done_cnt;
    @(negedge clk);
    cfg_data = cfg_a;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    nb = 0; prev = 0; guard = 0;
    while (nb < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (bready === 1'b1 && !prev) nb++;
      prev = bready;
    end
    chk("rst_reach_wresp", nb, 2);
    #2;
    chk("busy_before_rst", busy, 1'b1);
    rst_n = 0;
    #1;
    chk("async_reset", outvec(), RST_VEC);
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    chk("no_done_on_reset", done_cnt - base_done, 0);
    run_seq(cfg_a, -1, -1, -1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
